oai_n1_sdff_bank: RTL and testbench

- Multi-channel registered OAI cell model.
- Per channel, the combinational function is ZN = !((A[0] | ... | A[N-1]) & B).
- The result is captured in a scannable flop with clock enable, then passes through an optional retiming pipeline.
- Used as the functional/behavioural model for the compound OAI+scan-flop cells in the 9-track library, and as a bank primitive for datapath-style placement.

---
 rtl/oai_n1_sdff_bank_pkg.sv | 17 +
 rtl/oai_n1_stage.sv | 38 +++
 rtl/oai_n1_sdff_bank.sv | 83 ++++++++
 tb/tb_oai_n1_sdff_bank.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/oai_n1_sdff_bank_pkg.sv
// Shared definitions for the oai_*_sdff family of registered OAI bank models.
// Holds the reset value and the per-channel OAI term used by each sibling.
package oai_n1_sdff_bank_pkg;

  // Widest OR group the shared OAI helper accepts.
  localparam int OAI_MAX_N = 64;

  // Value every register in the bank takes on reset.
  localparam logic RST_VAL = 1'b0;

  // OAI term for one channel: ~((|group) & b).
  // Callers zero-extend their N-bit group; the extra zeros do not affect the OR.
  function automatic logic oai_term(input logic [OAI_MAX_N-1:0] grp, input logic b);
    return ~((|grp) & b);
  endfunction

endpackage

// File: rtl/oai_n1_stage.sv
// Scannable W-wide capture register.
// Priority on each rising edge: reset, then scan shift, then enabled capture, else hold.
module oai_n1_stage
  import oai_n1_sdff_bank_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         SE,
  input  logic         SI,
  input  logic         E,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);

  logic [W-1:0] shifted;

  // Next value in scan mode: shift toward the MSB, SI enters at bit 0, MSB drops out.
  always_comb begin
    // NOTE: assigning a default first on every path keeps always_comb free of latches.
    shifted    = Q << 1;
    shifted[0] = SI;
  end

  // Capture register with synchronous reset; SE takes priority over E.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (RST) begin
      Q <= {W{RST_VAL}};
    end else if (SE) begin
      Q <= shifted;
    end else if (E) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/oai_n1_sdff_bank.sv
// Multi-channel registered OAI bank: ZN[i] = ~((|A[i*N +: N]) & B[i]),
// captured in a scannable stage-1 flop, then retimed through STAGES-1 more registers.
module oai_n1_sdff_bank
  import oai_n1_sdff_bank_pkg::*;
#(
  parameter int N      = 2,
  parameter int CH     = 4,
  parameter int STAGES = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            E,
  input  logic            SE,
  input  logic            SI,
  input  logic [CH*N-1:0] A,
  input  logic [CH-1:0]   B,
  output logic [CH-1:0]   ZN,
  output logic            SO
);

  // Reject illegal shapes while elaborating rather than building a broken bank.
  if (N < 1 || N > OAI_MAX_N || CH < 1 || STAGES < 1) begin : g_param_check
    $error("oai_n1_sdff_bank: need 1 <= N <= %0d, CH >= 1, STAGES >= 1 (N=%0d CH=%0d STAGES=%0d)",
           OAI_MAX_N, N, CH, STAGES);
  end

  logic [CH-1:0]        f;
  logic [CH-1:0]        s1;
  logic [OAI_MAX_N-1:0] grp;

  // Combinational OAI core, one term per channel.
  always_comb begin
    f   = '0;
    grp = '0;
    for (int i = 0; i < CH; i++) begin
      grp        = '0;
      grp[N-1:0] = A[i*N +: N];
      f[i]       = oai_term(grp, B[i]);
    end
  end

  // Stage 1 also forms the scan chain; its MSB is the scan output.
  oai_n1_stage #(.W(CH)) u_stage1 (
    .CLK (CLK),
    .RST (RST),
    .SE  (SE),
    .SI  (SI),
    .E   (E),
    .D   (f),
    .Q   (s1)
  );

  assign SO = s1[CH-1];

  // Retiming stages 2..STAGES; they advance whenever stage 1 moves (capture or shift),
  // so the whole pipeline stalls together and scan traffic drains toward ZN.
  for (genvar k = 1; k < STAGES; k++) begin : g_pipe
    logic [CH-1:0] d;
    logic [CH-1:0] q;

    if (k == 1) begin : g_first
      assign d = s1;
    end else begin : g_chain
      assign d = g_pipe[k-1].q;
    end

    // Plain enable register with synchronous reset.
    always_ff @(posedge CLK) begin
      if (RST) begin
        q <= {CH{RST_VAL}};
      end else if (E | SE) begin
        q <= d;
      end
    end
  end

  if (STAGES == 1) begin : g_zn_direct
    assign ZN = s1;
  end else begin : g_zn_piped
    assign ZN = g_pipe[STAGES-1].q;
  end

endmodule

// File: tb/tb_oai_n1_sdff_bank.sv
// Bench for oai_n1_sdff_bank: one STAGES=1 and one STAGES=3 instance share stimulus.
// Outputs are sampled on the falling clock edge; inputs change there as well.
module tb_oai_n1_sdff_bank;

  logic       CLK = 1'b0;
  logic       RST, E, SE, SI;
  logic [7:0] A;
  logic [3:0] B;
  logic [3:0] zn1, zn3;
  logic       so1, so3;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  oai_n1_sdff_bank #(.N(2), .CH(4), .STAGES(1)) dut1 (
    .CLK (CLK), .RST (RST), .E (E), .SE (SE), .SI (SI),
    .A (A), .B (B), .ZN (zn1), .SO (so1)
  );

  oai_n1_sdff_bank #(.N(2), .CH(4), .STAGES(3)) dut3 (
    .CLK (CLK), .RST (RST), .E (E), .SE (SE), .SI (SI),
    .A (A), .B (B), .ZN (zn3), .SO (so3)
  );

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [3:0] zn;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  // One rising edge, then return at the falling edge for sampling/driving.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    // Hand-computed: ZN[i] = ~((A[2i+1] | A[2i]) & B[i]).
    vecs[0] = '{a: 8'h00, b: 4'hF, zn: 4'hF};
    vecs[1] = '{a: 8'hFF, b: 4'hF, zn: 4'h0};
    vecs[2] = '{a: 8'hFF, b: 4'h0, zn: 4'hF};
    vecs[3] = '{a: 8'hE4, b: 4'hF, zn: 4'h1};
    vecs[4] = '{a: 8'hE4, b: 4'h0, zn: 4'hF};
    vecs[5] = '{a: 8'hE4, b: 4'h5, zn: 4'hB};
    vecs[6] = '{a: 8'h39, b: 4'hF, zn: 4'h8};
    vecs[7] = '{a: 8'h39, b: 4'hA, zn: 4'hD};

    // Reset with inputs that would give f=0; RST wins regardless.
    RST = 1'b1; E = 1'b1; SE = 1'b0; SI = 1'b0; A = 8'hFF; B = 4'hF;
    step();
    check("reset_zn1", zn1, 4'h0);
    check("reset_so1", {3'b0, so1}, 4'h0);
    check("reset_zn3", zn3, 4'h0);
    RST = 1'b0;
    step();
    check("post_reset_zn1", zn1, 4'h0);

    // Truth table, one edge latency on STAGES=1; STAGES=3 lags by two vectors.
    for (int k = 0; k < 8; k++) begin
      A = vecs[k].a; B = vecs[k].b; E = 1'b1;
      step();
      check($sformatf("tt_zn1_%0d", k), zn1, vecs[k].zn);
      if (k >= 2) check($sformatf("tt_zn3_%0d", k), zn3, vecs[k-2].zn);
    end

    // Flush with f=0.
    A = 8'hFF; B = 4'hF;
    repeat (3) step();
    check("flush_zn3", zn3, 4'h0);

    // Latency with E held: f=A captured once, then f=0.
    A = 8'hFF; B = 4'h5;
    step();
    A = 8'hFF; B = 4'hF;
    step();
    check("lat_edge1_zn3", zn3, 4'h0);
    step();
    check("lat_edge2_zn3", zn3, 4'hA);
    repeat (3) step();
    check("lat_flush_zn3", zn3, 4'h0);

    // Same, but E=0 at the second edge stalls the whole pipeline.
    A = 8'hFF; B = 4'h5;
    step();
    A = 8'hFF; B = 4'hF; E = 1'b0;
    step();
    check("stall_hold_zn1", zn1, 4'hA);
    check("stall_edge1_zn3", zn3, 4'h0);
    E = 1'b1;
    step();
    check("stall_edge2_zn3", zn3, 4'h0);
    step();
    check("stall_edge3_zn3", zn3, 4'hA);
    repeat (3) step();
    check("stall_flush_zn3", zn3, 4'h0);

    // Scan shift 1,0,1,1 with E=1 and f=0 present: SE must win.
    SE = 1'b1;
    SI = 1'b1; step(); check("scan_so_e1", {3'b0, so1}, 4'h0);
    SI = 1'b0; step(); check("scan_so_e2", {3'b0, so1}, 4'h0);
    SI = 1'b1; step(); check("scan_so_e3", {3'b0, so1}, 4'h0);
    SI = 1'b1; step(); check("scan_so_e4", {3'b0, so1}, 4'h1);
    check("scan_s1", zn1, 4'b1011);
    check("scan_drain_zn3", zn3, 4'b0010);

    // RST, SE and E together with SI=1: reset wins.
    RST = 1'b1; SE = 1'b1; E = 1'b1; SI = 1'b1;
    step();
    check("collide_zn1", zn1, 4'h0);
    check("collide_so1", {3'b0, so1}, 4'h0);
    check("collide_zn3", zn3, 4'h0);
    RST = 1'b0; SE = 1'b0; SI = 1'b0;

    // Fill STAGES=3 with f=F, reset mid-stream, then refill.
    A = 8'h00; B = 4'hF;
    repeat (3) step();
    check("fill_zn3", zn3, 4'hF);
    RST = 1'b1;
    step();
    check("mid_reset_zn3", zn3, 4'h0);
    check("mid_reset_so3", {3'b0, so3}, 4'h0);
    RST = 1'b0;
    step(); check("refill_e1_zn3", zn3, 4'h0);
    step(); check("refill_e2_zn3", zn3, 4'h0);
    step(); check("refill_e3_zn3", zn3, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
